// File: rtl/pci_target_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pci_target_mem_pkg
// Description : Shared definitions for the PCI memory target: bus command
//               codes, active-low signal levels, FSM state encoding and
//               command classification helpers.
// Revision    : 1.0  initial release
// ============================================================================
package pci_target_mem_pkg;

    // Active-low PCI control levels
    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

    // Memory commands claimed by the target
    localparam logic [3:0] CMD_MEM_READ       = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE      = 4'b0111;
    localparam logic [3:0] CMD_MEM_READ_MULT  = 4'b1100;
    localparam logic [3:0] CMD_MEM_READ_LINE  = 4'b1110;
    localparam logic [3:0] CMD_MEM_WRITE_INV  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BUSY  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOPW = 3'd4,
        ST_TURN  = 3'd5
    } state_t;

    function automatic logic cmd_is_read(input logic [3:0] cmd);
        return (cmd == CMD_MEM_READ) || (cmd == CMD_MEM_READ_MULT) ||
               (cmd == CMD_MEM_READ_LINE);
    endfunction

    function automatic logic cmd_is_write(input logic [3:0] cmd);
        return (cmd == CMD_MEM_WRITE) || (cmd == CMD_MEM_WRITE_INV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pci_target_ram.sv
`default_nettype none
// ============================================================================
// Module      : pci_target_ram
// Description : 2**DEPTH_LOG2 x 32 storage with per-byte write enables and
//               asynchronous read. Contents are not reset.
// Ports       : clk      in   write clock
//               addr     in   dword index (shared by read and write)
//               byte_we  in   active-high write enable per byte lane
//               wdata    in   write data
//               rdata    out  combinational read of mem[addr]
// Revision    : 1.0  initial release
// ============================================================================
module pci_target_ram
    import pci_target_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [3:0]            byte_we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [3:0][7:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (byte_we[b]) begin
                mem[addr][b] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/pci_target_mem.sv
`default_nettype none
// ============================================================================
// Module      : pci_target_mem
// Description : Parametrised PCI memory target. Claims memory read/write
//               bursts inside a 4*2**DEPTH_LOG2 byte window at BASE_ADDR and
//               services them from internal RAM, with byte enables,
//               programmable initial wait states, master wait states and a
//               target disconnect at the end of the window.
// Ports       : Clock        in    bus clock, rising-edge sampling
//               RST          in    synchronous active-high reset
//               Frame        in    active-low cycle framing
//               Irdy         in    active-low initiator ready
//               CBE          in    command / active-low byte enables
//               AddressData  inout multiplexed bus, driven in read data phases
//               Devsel       out   active-low device select
//               Trdy         out   active-low target ready
//               Stop         out   active-low disconnect request
// Revision    : 1.0  initial release
// ============================================================================
module pci_target_mem
    import pci_target_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          DEPTH_LOG2  = 4,
    parameter int          WAIT_STATES = 0
) (
    input  logic        Clock,
    input  logic        RST,
    input  logic        Frame,
    input  logic        Irdy,
    input  logic [3:0]  CBE,
    inout  wire  [31:0] AddressData,
    output logic        Devsel,
    output logic        Trdy,
    output logic        Stop
);

    localparam int                    ADDR_LSB = DEPTH_LOG2 + 2;
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

    state_t                state, state_nx;
    logic [DEPTH_LOG2-1:0] idx, idx_nx;
    logic                  is_read, is_read_nx;
    logic [3:0]            wait_cnt, wait_cnt_nx;

    logic                  addr_hit;
    logic [3:0]            wait_total;
    logic                  drive_ad;
    logic                  ram_we;
    logic [3:0]            byte_we;
    logic [31:0]           ram_rdata;
    logic                  unused_bits;

    // Linear bursts only: the low address bits carry no meaning here.
    assign unused_bits = ^AddressData[1:0];

    // Reads spend one extra cycle in WAIT for the bus turnaround.
    assign wait_total = 4'(WAIT_STATES) + {3'b000, cmd_is_read(CBE)};

    assign addr_hit = (AddressData[31:ADDR_LSB] == BASE_ADDR[31:ADDR_LSB]) &&
                      (cmd_is_read(CBE) || cmd_is_write(CBE));

    always_ff @(posedge Clock) begin
        if (RST) begin
            state    <= ST_IDLE;
            idx      <= '0;
            is_read  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            is_read  <= is_read_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        is_read_nx  = is_read;
        wait_cnt_nx = wait_cnt;
        Devsel      = DEASSERTED;
        Trdy        = DEASSERTED;
        Stop        = DEASSERTED;
        drive_ad    = 1'b0;
        ram_we      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (Frame == ASSERTED) begin
                    is_read_nx = cmd_is_read(CBE);
                    idx_nx     = AddressData[ADDR_LSB-1:2];
                    if (!addr_hit) begin
                        state_nx = ST_BUSY;
                    end else if (wait_total == 4'd0) begin
                        state_nx = ST_DATA;
                    end else begin
                        state_nx    = ST_WAIT;
                        wait_cnt_nx = wait_total - 4'd1;
                    end
                end
            end

            // Another agent owns this transaction; wait for the bus to go idle.
            ST_BUSY: begin
                if ((Frame == DEASSERTED) && (Irdy == DEASSERTED)) begin
                    state_nx = ST_IDLE;
                end
            end

            ST_WAIT: begin
                Devsel = ASSERTED;
                if (wait_cnt == 4'd0) begin
                    state_nx = ST_DATA;
                end else begin
                    wait_cnt_nx = wait_cnt - 4'd1;
                end
            end

            ST_DATA: begin
                Devsel   = ASSERTED;
                Trdy     = ASSERTED;
                drive_ad = is_read;
                // Disconnect only if the master wants to continue past the
                // last dword; a final phase at the window end is normal.
                if ((idx == LAST_IDX) && (Frame == ASSERTED)) begin
                    Stop = ASSERTED;
                end
                if (Irdy == ASSERTED) begin
                    ram_we = !is_read;
                    if (Frame == DEASSERTED) begin
                        state_nx = ST_TURN;
                    end else if (idx == LAST_IDX) begin
                        state_nx = ST_STOPW;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end

            ST_STOPW: begin
                Devsel = ASSERTED;
                Stop   = ASSERTED;
                if (Frame == DEASSERTED) begin
                    state_nx = ST_TURN;
                end
            end

            ST_TURN: begin
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign byte_we     = (~CBE) & {4{ram_we}};
    assign AddressData = drive_ad ? ram_rdata : 32'bz;

    pci_target_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (Clock),
        .addr    (idx),
        .byte_we (byte_we),
        .wdata   (AddressData),
        .rdata   (ram_rdata)
    );

endmodule
`default_nettype wire
